hex_scroll_ctrl: RTL
====================

Name: hex_scroll_ctrl

Overview:
- Scrolling controller for the four-digit seven-segment character display.
- Holds a 4-slot ring of 2-bit character codes and rotates it one position every TICKS clock cycles.
- Decodes every slot onto HEX3..HEX0.
- Sits between the board switches (run/direction/load/pattern) and the HEX outputs, so one character decoder is reused for all four displays.

Parameters:
- TICKS, 50000000, clock cycles per scroll step; legal range ≥ 1.
- CW, 26, prescaler counter width; must satisfy 2^CW ≥ TICKS.

Ports:
- CLOCK_50  in  1  system clock; all state changes on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on CLOCK_50 rising edge.
- run  in  1  1 = scrolling enabled; 0 = hold current ring.
- dir  in  1  0 = rotate toward HEX3 (left); 1 = rotate toward HEX0 (right).
- load  in  1  1 = replace ring with pattern this cycle.
- pattern  in  8  slot i code at bits [2i+1:2i].
- HEX0..HEX3  out  7 each  active-low segments; bit0 = a, bit1 = b … bit6 = g.
- step  out  1  one-cycle pulse, high in the cycle the ring has just rotated.

Behaviour:
- Character codes (active-low segments g..a):
  - 00 = 'd' = 0100001
  - 01 = 'E' = 0000110
  - 10 = '1' = 1111001
  - 11 = blank = 1111111
- Ring storage: buf[7:0]; slot i drives HEXi.
- Reset (resetn = 0 at an edge):
  - buf = 00_01_10_11, i.e. HEX3 'd', HEX2 'E', HEX1 '1', HEX0 blank.
  - cnt = 0, state = IDLE, step = 0.
  - HEX outputs = reset decode of buf (HEX3 0100001, HEX2 0000110, HEX1 1111001, HEX0 1111111).
  - Reset overrides load and run.
- FSM states IDLE and RUN:
  - IDLE → RUN on an edge with run = 1.
  - RUN → IDLE on an edge with run = 0.
  - In IDLE, cnt holds 0.
- Prescaler (RUN with run = 1, load = 0):
  - cnt < TICKS-1: cnt ← cnt+1.
  - cnt == TICKS-1: cnt ← 0, buf ← rotated, step ← 1.
  - step is 0 in every other cycle.
- Leaving RUN (run = 0 while in RUN): cnt ← 0 at that edge. A partial count is discarded and no step occurs.
- Rotation:
  - dir = 0: slot i ← slot i-1 for i = 1..3, slot0 ← slot3.
  - dir = 1: slot i ← slot i+1 for i = 0..2, slot3 ← slot0.
  - dir is sampled only on the step edge.
- Load, in any state:
  - buf ← pattern, cnt ← 0, step ← 0.
  - load beats a coincident step.
  - State transitions still follow run.
- Timing:
  - First step occurs TICKS edges after the edge that moved IDLE → RUN.
  - HEX outputs are registered from buf, so they change one edge after buf (step and the new HEX value are visible in consecutive cycles).
- TICKS = 1: rotates on every edge while in RUN with run = 1.
- Continuous run: rotation wraps indefinitely; after 4 steps in the same direction the ring equals its starting value.

Test Plan:
1. Reset with TICKS=4: hold resetn=0 for 2 edges, then release with run=0 for 10 cycles → HEX3..HEX0 = 0100001, 0000110, 1111001, 1111111; step never high; values unchanged.
2. Left scroll: run=1, dir=0 → step high exactly 4 edges after entry to RUN, buf = 01_10_11_00, next cycle HEX3 = 'E', HEX0 = 'd'. After 16 edges total, buf returns to 00_01_10_11.
3. Right scroll, direction change mid-run: after one left step, set dir=1 two cycles before the next step → that step yields buf = 00_01_10_11 again.
4. Pause: run=1 for 2 cycles, run=0 for 5, run=1 again → no step until 4 edges after re-entry to RUN; buf unchanged during the pause.
5. Load/step collision: load=1 with pattern=8'hE4 on the same edge cnt==3 → buf = E4 (HEX3 blank, HEX2 '1', HEX1 'E', HEX0 'd'), step = 0, next step 4 edges later.
6. Reset mid-operation: assert resetn=0 when cnt=2 with load=1 → buf = 00_01_10_11, cnt = 0, IDLE. With TICKS=1, run=1 → step every cycle, and the ring repeats every 4 cycles.

Source files
------------

// File: rtl/hex_scroll_ctrl_if.sv
// Switch-side controls and HEX-side outputs of the scrolling display controller.
interface hex_scroll_ctrl_if;
  logic       run;
  logic       dir;
  logic       load;
  logic [7:0] pattern;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic       step;

  modport master (
    output run, dir, load, pattern,
    input  HEX0, HEX1, HEX2, HEX3, step
  );

  modport slave (
    input  run, dir, load, pattern,
    output HEX0, HEX1, HEX2, HEX3, step
  );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Four-slot character ring rotated every TICKS cycles; each slot is decoded
// through one shared character table onto the active-low HEX displays.
module hex_scroll_ctrl #(
  parameter int TICKS = 50000000,
  parameter int CW    = 26
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  hex_scroll_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [7:0]    RING_RST = 8'b00_01_10_11;
  localparam logic [27:0]   HEX_RST  = {7'b0100001, 7'b0000110, 7'b1111001, 7'b1111111};

  function automatic logic [6:0] seg_decode(input logic [1:0] code);
    logic [6:0] seg;
    case (code)
      2'b00:   seg = 7'b0100001;
      2'b01:   seg = 7'b0000110;
      2'b10:   seg = 7'b1111001;
      2'b11:   seg = 7'b1111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ring_q, ring_d;
  logic          step_q, step_d;
  logic [27:0]   hex_q, hex_d;

  // Next-state, prescaler, rotation/load and display decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_ZERO;
    ring_d  = ring_q;
    step_d  = 1'b0;

    if (bus.run) begin
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end

    // Load wins over a coincident step; leaving RUN or idling clears the count.
    if (bus.load) begin
      ring_d = bus.pattern;
      cnt_d  = CNT_ZERO;
    end else if ((state_q == RUN) && bus.run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = CNT_ZERO;
        step_d = 1'b1;
        if (bus.dir) begin
          ring_d = {ring_q[1:0], ring_q[7:2]};
        end else begin
          ring_d = {ring_q[5:0], ring_q[7:6]};
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end

    hex_d = {seg_decode(ring_q[7:6]), seg_decode(ring_q[5:4]),
             seg_decode(ring_q[3:2]), seg_decode(ring_q[1:0])};
  end

  // State, counter, ring and registered display outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      ring_q  <= RING_RST;
      step_q  <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_d;
      step_q  <= step_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.HEX3 = hex_q[27:21];
  assign bus.HEX2 = hex_q[20:14];
  assign bus.HEX1 = hex_q[13:7];
  assign bus.HEX0 = hex_q[6:0];
  assign bus.step = step_q;

endmodule
